// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, next-PC selection, halt/fault state machine.
// Optional INSTR_COUNT_EN adds a saturating retired-instruction counter port.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                  IMEM_DEPTH  = 256,
    parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_rdata,
    input  logic                          stall,
    input  logic                          branch,
    input  logic                          zero,
    input  logic                          jump,
    output logic [31:0]                   instr,
    output logic [5:0]                    opcode,
    output logic [PC_WIDTH-1:0]           pc,
    output logic [PC_WIDTH-1:0]           pc_plus4,
    output logic                          halted,
    output logic                          fetch_fault
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0]                   retired_count
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] br_off;
    logic                in_run;
    logic                out_of_range;
    logic                advance;

    assign in_run    = (state_q == ST_RUN);
    assign instr     = in_run ? imem_rdata : 32'h0;
    assign opcode    = instr[31:26];
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q[AW+1:2];

    assign halted      = (state_q == ST_HALT);
    assign fetch_fault = (state_q == ST_FAULT);

    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Jump beats branch; an untaken branch falls through to pc_plus4.
    always_comb begin
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + br_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // Any set bit above the word-index field means the target lies past the memory.
    assign out_of_range = |next_pc[PC_WIDTH-1:AW+2];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        advance = 1'b0;
        if (in_run && !stall) begin
            if (opcode == HALT_OPCODE) begin
                state_d = ST_HALT;
            end else if (out_of_range) begin
                state_d = ST_FAULT;
            end else begin
                advance = 1'b1;
            end
        end
    end

    assign pc_d = advance ? next_pc : pc_q;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] count_q, count_d;

    assign count_d       = (advance && count_q != 32'hFFFF_FFFF) ? count_q + 32'd1 : count_q;
    assign retired_count = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus randomized programs
// checked against a behavioural model of the fetch rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc, pc_plus4;
    logic        halted, fetch_fault;
`ifdef INSTR_COUNT_EN
    logic [31:0] retired_count;
`endif

    logic [31:0] mem [256];
    assign imem_rdata = mem[imem_addr];

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .fetch_fault (fetch_fault)
`ifdef INSTR_COUNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    always #5 clk = ~clk;

    typedef enum {M_RUN, M_HALT, M_FAULT} mode_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          halted;
        bit          fault;
        logic [31:0] count;
    } exp_t;

    exp_t        exp_q[$];
    event        sample_ev;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    mode_t       m_mode;
    logic [31:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.pc     = m_pc;
        e.instr  = (m_mode == M_RUN) ? mem[m_pc / 4] : 32'h0;
        e.halted = (m_mode == M_HALT);
        e.fault  = (m_mode == M_FAULT);
        e.count  = m_count;
        return e;
    endfunction

    // Behavioural model of one clock edge.
    task automatic model_step(input bit st, input bit br, input bit z, input bit jp);
        logic [31:0] ins, p4, tgt;
        int          off;
        if (m_mode != M_RUN || st) return;
        ins = mem[m_pc / 4];
        if (ins[31:26] == 6'h3F) begin
            m_mode = M_HALT;
            return;
        end
        p4  = m_pc + 32'd4;
        off = $signed(ins[15:0]);
        if (jp)            tgt = (p4 & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4;
        else if (br && z)  tgt = p4 + 32'(off * 4);
        else               tgt = p4;
        if (tgt / 4 >= 256) begin
            m_mode = M_FAULT;
        end else begin
            m_pc = tgt;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end
    endtask

    // Called at a negedge; drives one cycle and leaves at the following negedge.
    task automatic cycle(input bit st, input bit br, input bit z, input bit jp);
        stall = st; branch = br; zero = z; jump = jp;
        model_step(st, br, z, jp);
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic reset_assert();
        #2;
        reset = 1'b0;
        stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        m_pc = 32'h0; m_mode = M_RUN; m_count = 32'h0;
        exp_q.push_back(snapshot());
        ->sample_ev;
        #2;
    endtask

    task automatic reset_release();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    // Monitor: compares whenever an expected response is due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("pc_plus4", pc_plus4, e.pc + 32'd4);
                check("imem_addr", 32'(imem_addr), (e.pc >> 2) & 32'hFF);
                check("instr", instr, e.instr);
                check("opcode", 32'(opcode), e.instr >> 26);
                check("halted", 32'(halted), 32'(e.halted));
                check("fetch_fault", 32'(fetch_fault), 32'(e.fault));
`ifdef INSTR_COUNT_EN
                check("retired_count", retired_count, e.count);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          kind;
        clear_mem();
        @(negedge clk);

        // Sequential fetch from reset.
        reset_assert();
        for (int i = 0; i < 256; i++) mem[i] = {6'(i % 63), 26'(i * 32'h1357)};
        reset_release();
        repeat (4) cycle(0, 0, 0, 0);

        // Taken and untaken branch at pc = 8.
        reset_assert();
        clear_mem();
        mem[2] = 32'h1000_FFFE;
        reset_release();
        repeat (2) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);

        // Jump wins over branch.
        reset_assert();
        clear_mem();
        mem[2] = 32'h1000_0010;
        reset_release();
        repeat (2) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 1);
        cycle(0, 0, 0, 0);

        // Stall at 0x10, including a held halt instruction.
        reset_assert();
        clear_mem();
        mem[4] = 32'hFC00_0000;
        reset_release();
        repeat (4) cycle(0, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 1);
        mem[4] = 32'h0;
        reset_assert();
        reset_release();
        repeat (4) cycle(0, 0, 0, 0);
        repeat (3) cycle(1, 1, 1, 0);
        cycle(0, 0, 0, 0);

        // Halt at 0x20, then inputs ignored, then async reset from HALT.
        reset_assert();
        clear_mem();
        mem[8] = 32'hFC00_0000;
        reset_release();
        repeat (9) cycle(0, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 1);
        reset_assert();
        reset_release();
        repeat (2) cycle(0, 0, 0, 0);

        // Fault stepping past 0x3FC, then async reset from FAULT.
        reset_assert();
        clear_mem();
        mem[0] = 32'h0800_00FF;
        reset_release();
        cycle(0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0);
        reset_assert();
        clear_mem();
        mem[0] = 32'h0800_0100;
        reset_release();
        cycle(0, 0, 0, 1);
        repeat (2) cycle(1, 0, 0, 0);
        reset_assert();
        reset_release();
        repeat (2) cycle(0, 0, 0, 0);

        // Randomized programs and control inputs.
        for (int r = 0; r < 8; r++) begin
            reset_assert();
            for (int i = 0; i < 256; i++) begin
                kind = $urandom_range(0, 29);
                if (kind == 0)
                    w = {6'h3F, 26'($urandom)};
                else if (kind < 8)
                    w = {6'($urandom_range(0, 62)), 26'($urandom_range(0, 290))};
                else
                    w = {6'($urandom_range(0, 62)), 10'($urandom),
                         16'($signed($urandom_range(0, 24)) - 12)};
                mem[i] = w;
            end
            reset_release();
            for (int c = 0; c < 150; c++)
                cycle($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
